// File: rtl/nw_vc_alloc_tracked.sv
// Virtual-channel allocator: one round-robin arbiter per output port binds a requesting input VC
// to the lowest free output VC and tracks output-VC busy state. Optional: NW_VCA_PRIORITY_EN.
module nw_vc_alloc_tracked #(
  parameter int np  = 5,
  parameter int nv  = 4,
  parameter int nvw = 2
`ifdef NW_VCA_PRIORITY_EN
  ,
  parameter int pw  = 2
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [np*nv*np-1:0]   req,
`ifdef NW_VCA_PRIORITY_EN
  input  logic [np*nv*pw-1:0]   req_pri,
`endif
  input  logic [np*nv-1:0]      vc_release,
  output logic [np*nv-1:0]      gnt,
  output logic [np*nv*nvw-1:0]  gnt_ovc,
  output logic [np*nv-1:0]      ovc_busy
);

  localparam int ni = np * nv;
  localparam int iw = (ni > 1) ? $clog2(ni) : 1;

  logic [ni-1:0]               gnt_q, gnt_d;
  logic [ni*nvw-1:0]           gnt_ovc_q, gnt_ovc_d;
  logic [ni-1:0]               ovc_busy_q, ovc_busy_d;
  logic [np-1:0][iw-1:0]       ptr_q, ptr_d;

  logic [np-1:0]               op_fire;
  logic [np-1:0][iw-1:0]       op_win;
  logic [np-1:0][nvw-1:0]      op_ovc;

  genvar gi;
  generate
    for (gi = 0; gi < np; gi++) begin : g_op
      logic [ni-1:0]  cand;
      logic [ni-1:0]  elig;
      logic [nv-1:0]  free_vec;
      logic           found;
      logic [iw-1:0]  win;
      logic [nvw-1:0] ovc;

      // A requester whose grant is visible this cycle is dropping its request; ignore it.
      always_comb begin
        for (int k = 0; k < ni; k++) begin
          cand[k] = req[k*np+gi] & ~gnt_q[k];
        end
        free_vec = ~ovc_busy_q[gi*nv +: nv];
      end

`ifdef NW_VCA_PRIORITY_EN
      logic [pw-1:0] max_pri;
      always_comb begin
        max_pri = '0;
        for (int k = 0; k < ni; k++) begin
          if (cand[k] && (req_pri[k*pw +: pw] > max_pri)) max_pri = req_pri[k*pw +: pw];
        end
        for (int k = 0; k < ni; k++) begin
          elig[k] = cand[k] && (req_pri[k*pw +: pw] == max_pri);
        end
      end
`else
      assign elig = cand;
`endif

      always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        ovc   = '0;
        for (int off = 0; off < ni; off++) begin
          idx = int'(ptr_q[gi]) + off;
          if (idx >= ni) idx = idx - ni;
          if (!found && elig[idx]) begin
            found = 1'b1;
            win   = iw'(idx);
          end
        end
        // Descending scan leaves the lowest free index.
        for (int v = nv - 1; v >= 0; v--) begin
          if (free_vec[v]) ovc = nvw'(v);
        end
      end

      assign op_fire[gi] = found & (|free_vec);
      assign op_win[gi]  = win;
      assign op_ovc[gi]  = ovc;
    end
  endgenerate

  // Allocation reads the pre-release busy vector; a VC freed this cycle is grantable next cycle.
  always_comb begin
    gnt_d      = '0;
    gnt_ovc_d  = '0;
    ovc_busy_d = ovc_busy_q & ~vc_release;
    ptr_d      = ptr_q;
    for (int op = 0; op < np; op++) begin
      if (op_fire[op]) begin
        gnt_d[op_win[op]]                          = 1'b1;
        gnt_ovc_d[int'(op_win[op])*nvw +: nvw]     = op_ovc[op];
        ovc_busy_d[op*nv + int'(op_ovc[op])]       = 1'b1;
        ptr_d[op] = (op_win[op] == iw'(ni - 1)) ? '0 : op_win[op] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      gnt_ovc_q  <= '0;
      ovc_busy_q <= '0;
      ptr_q      <= '0;
    end else begin
      gnt_q      <= gnt_d;
      gnt_ovc_q  <= gnt_ovc_d;
      ovc_busy_q <= ovc_busy_d;
      ptr_q      <= ptr_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_ovc  = gnt_ovc_q;
  assign ovc_busy = ovc_busy_q;

endmodule
